// File: rtl/counter_pkg.sv
// counter_pkg: seven-segment patterns and segment indices shared by the hex counter.
package counter_pkg;
   typedef enum int unsigned {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G} seg_idx_e;
   // Active-low, bit 0 = a .. bit 6 = g; entry 0 is the rightmost slice.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };
endpackage

// File: rtl/seg7_hex.sv
// seg7_hex: 4-bit value to active-low seven-segment pattern.
module seg7_hex
   import counter_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);
   assign seg_o = SEG_TABLE[digit_i];
endmodule

// File: rtl/updown_counter_hex.sv
// updown_counter_hex: modulo up/down counter with load, wrap/saturate and hex readout.
module updown_counter_hex #(
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 255,
   parameter int DIGITS  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                up,
   input  logic                saturate,
   input  logic                load,
   input  logic [WIDTH-1:0]    load_value,
   output logic [WIDTH-1:0]    count,
   output logic                wrap,
   output logic                at_limit,
   output logic [7*DIGITS-1:0] hex
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
   logic [WIDTH-1:0]    count_q, count_d;
   logic                wrap_q, wrap_d;
   logic [4*DIGITS-1:0] nib;
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) count_d = load_value > MAX ? MAX : load_value;
      else if (enable && up) begin
         if (count_q != MAX) count_d = count_q + 1'b1;
         else if (!saturate) begin
            count_d = '0;
            wrap_d  = 1'b1;
         end
      end else if (enable) begin
         if (count_q != '0) count_d = count_q - 1'b1;
         else if (!saturate) begin
            count_d = MAX;
            wrap_d  = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end
   assign count    = count_q;
   assign wrap     = wrap_q;
   assign at_limit = up ? count_q == MAX : count_q == '0;
   // Digits beyond WIDTH read as zero.
   assign nib = (4*DIGITS)'(count_q);
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      seg7_hex u_seg (.digit_i(nib[4*i +: 4]), .seg_o(hex[7*i +: 7]));
   end
endmodule

// File: tb/tb_updown_counter_hex.sv
// tb_updown_counter_hex: directed scenarios plus randomized run against a modulo-arithmetic model.
module tb_updown_counter_hex;
   logic clk = 1'b0, reset = 1'b1, enable = 1'b0, up = 1'b1, saturate = 1'b0, load = 1'b0;
   logic [11:0] lv = '0;
   logic [7:0]  c0, c1, c2;
   logic [11:0] c3;
   logic [13:0] h0, h1, h2;
   logic [20:0] h3;
   logic [3:0]  w, al;
   logic [11:0] cnt [4];
   logic [20:0] hx [4];
   int checks = 0, failures = 0;
   int maxv [4] = '{255, 9, 100, 3000};
   int ndig [4] = '{2, 2, 2, 3};
   int m [4] = '{0, 0, 0, 0};
   bit mw [4] = '{0, 0, 0, 0};
   logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   updown_counter_hex #(.WIDTH(8), .MAX_VAL(255), .DIGITS(2)) u0 (.clk(clk), .reset(reset),
      .enable(enable), .up(up), .saturate(saturate), .load(load), .load_value(lv[7:0]),
      .count(c0), .wrap(w[0]), .at_limit(al[0]), .hex(h0));
   updown_counter_hex #(.WIDTH(8), .MAX_VAL(9), .DIGITS(2)) u1 (.clk(clk), .reset(reset),
      .enable(enable), .up(up), .saturate(saturate), .load(load), .load_value(lv[7:0]),
      .count(c1), .wrap(w[1]), .at_limit(al[1]), .hex(h1));
   updown_counter_hex #(.WIDTH(8), .MAX_VAL(100), .DIGITS(2)) u2 (.clk(clk), .reset(reset),
      .enable(enable), .up(up), .saturate(saturate), .load(load), .load_value(lv[7:0]),
      .count(c2), .wrap(w[2]), .at_limit(al[2]), .hex(h2));
   updown_counter_hex #(.WIDTH(12), .MAX_VAL(3000), .DIGITS(3)) u3 (.clk(clk), .reset(reset),
      .enable(enable), .up(up), .saturate(saturate), .load(load), .load_value(lv),
      .count(c3), .wrap(w[3]), .at_limit(al[3]), .hex(h3));

   assign cnt[0] = {4'h0, c0};
   assign cnt[1] = {4'h0, c1};
   assign cnt[2] = {4'h0, c2};
   assign cnt[3] = c3;
   assign hx[0]  = {7'h0, h0};
   assign hx[1]  = {7'h0, h1};
   assign hx[2]  = {7'h0, h2};
   assign hx[3]  = h3;

   function automatic logic [20:0] exp_hex(int v, int nd);
      logic [20:0] r = '0;
      for (int d = 0; d < nd; d++) r |= 21'(tbl[(v >> (4*d)) & 15]) << (7*d);
      return r;
   endfunction

   // Advance one clock; the model applies the behavioural rules with modulo arithmetic.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         int mx = maxv[i];
         int l = (i == 3) ? int'(lv) : int'(lv[7:0]);
         if (reset) begin m[i] = 0; mw[i] = 0; end
         else if (load) begin m[i] = l > mx ? mx : l; mw[i] = 0; end
         else if (enable && up && !(m[i] == mx && saturate)) begin
            mw[i] = m[i] == mx; m[i] = (m[i] + 1) % (mx + 1);
         end else if (enable && !up && !(m[i] == 0 && saturate)) begin
            mw[i] = m[i] == 0; m[i] = (m[i] + mx) % (mx + 1);
         end else mw[i] = 0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1; load = 1; enable = 1; lv = 12'h123;
      tick();
      tick();
      reset = 0; load = 0; enable = 0; up = 0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks += 4;
         if (cnt[i] !== 12'd0) begin failures++; $display("FAIL reset_count[%0d]: got %0d expected 0", i, cnt[i]); end
         if (w[i] !== 1'b0) begin failures++; $display("FAIL reset_wrap[%0d]: got %b expected 0", i, w[i]); end
         if (al[i] !== 1'b1) begin failures++; $display("FAIL reset_atlim_down[%0d]: got %b expected 1", i, al[i]); end
         if (hx[i] !== exp_hex(0, ndig[i])) begin failures++; $display("FAIL reset_hex[%0d]: got %h expected %h", i, hx[i], exp_hex(0, ndig[i])); end
      end
      up = 1;
      #1;
      checks++;
      if (al !== 4'b0000) begin failures++; $display("FAIL reset_atlim_up: got %b expected 0000", al); end
   endtask

   task automatic test_full_wrap();
      int wraps1 = 0;
      enable = 1; up = 1; saturate = 0;
      for (int k = 1; k <= 256; k++) begin
         tick();
         checks += 2;
         if (c0 !== 8'(k % 256)) begin failures++; $display("FAIL wrap_count k=%0d: got %0d expected %0d", k, c0, k % 256); end
         if (w[0] !== (k == 256)) begin failures++; $display("FAIL wrap_pulse k=%0d: got %b expected %b", k, w[0], k == 256); end
         if (w[1]) wraps1++;
      end
      checks += 2;
      if (h0 !== {7'h40, 7'h40}) begin failures++; $display("FAIL wrap_hex: got %h expected %h", h0, {7'h40, 7'h40}); end
      if (wraps1 != 25) begin failures++; $display("FAIL wrap_period_max9: got %0d pulses expected 25", wraps1); end
      enable = 0;
   endtask

   task automatic test_saturate();
      reset = 1;
      tick();
      reset = 0; enable = 1; up = 1; saturate = 1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         checks += 2;
         if (c1 !== 8'(k > 9 ? 9 : k)) begin failures++; $display("FAIL sat_count k=%0d: got %0d expected %0d", k, c1, k > 9 ? 9 : k); end
         if (w[1] !== 1'b0) begin failures++; $display("FAIL sat_wrap k=%0d: got %b expected 0", k, w[1]); end
      end
      checks++;
      if (al[1] !== 1'b1) begin failures++; $display("FAIL sat_atlim: got %b expected 1", al[1]); end
      up = 0;
      #1;
      checks++;
      if (al[1] !== 1'b0) begin failures++; $display("FAIL sat_atlim_down: got %b expected 0", al[1]); end
      enable = 0; saturate = 0;
   endtask

   task automatic test_load_clamp();
      load = 1; lv = 12'h0C8; up = 0;
      tick();
      checks += 3;
      if (c2 !== 8'd100) begin failures++; $display("FAIL load_clamp100: got %0d expected 100", c2); end
      if (c1 !== 8'd9) begin failures++; $display("FAIL load_clamp9: got %0d expected 9", c1); end
      if (c0 !== 8'd200) begin failures++; $display("FAIL load_noclamp: got %0d expected 200", c0); end
      enable = 1; up = 1;
      tick();
      tick();
      checks += 2;
      if (c2 !== 8'd100) begin failures++; $display("FAIL load_hold: got %0d expected 100", c2); end
      if (w[2] !== 1'b0) begin failures++; $display("FAIL load_wrap: got %b expected 0", w[2]); end
      load = 0; enable = 0;
   endtask

   task automatic test_count_down();
      logic [7:0] exp_c [3] = '{8'd1, 8'd0, 8'd255};
      load = 1; lv = 12'd2;
      tick();
      load = 0; enable = 1; up = 0; saturate = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks += 2;
         if (c0 !== exp_c[k]) begin failures++; $display("FAIL down_count step%0d: got %0d expected %0d", k, c0, exp_c[k]); end
         if (w[0] !== (k == 2)) begin failures++; $display("FAIL down_wrap step%0d: got %b expected %b", k, w[0], k == 2); end
      end
      checks++;
      if (h0 !== {7'h0E, 7'h0E}) begin failures++; $display("FAIL down_hex: got %h expected %h", h0, {7'h0E, 7'h0E}); end
      enable = 0;
   endtask

   task automatic test_reset_priority();
      load = 1; lv = 12'd77;
      tick();
      checks++;
      if (c0 !== 8'd77) begin failures++; $display("FAIL prio_setup: got %0d expected 77", c0); end
      reset = 1; load = 1; enable = 1; lv = 12'd50;
      tick();
      checks += 2;
      if (c0 !== 8'd0) begin failures++; $display("FAIL prio_count: got %0d expected 0", c0); end
      if (w[0] !== 1'b0) begin failures++; $display("FAIL prio_wrap: got %b expected 0", w[0]); end
      reset = 0; load = 0; up = 1;
      tick();
      checks++;
      if (c0 !== 8'd1) begin failures++; $display("FAIL prio_resume: got %0d expected 1", c0); end
      enable = 0;
   endtask

   task automatic test_hex12();
      load = 1; lv = 12'hA5C;
      tick();
      load = 0;
      checks += 2;
      if (c3 !== 12'hA5C) begin failures++; $display("FAIL hex12_count: got %h expected a5c", c3); end
      if (h3 !== {7'h08, 7'h12, 7'h46}) begin failures++; $display("FAIL hex12_digits: got %h expected %h", h3, {7'h08, 7'h12, 7'h46}); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom % 60) == 0;
         load = ($urandom % 12) == 0;
         enable = ($urandom % 4) != 0;
         up = 1'($urandom);
         saturate = 1'($urandom);
         lv = 12'($urandom);
         tick();
         for (int i = 0; i < 4; i++) begin
            bit exp_al = up ? m[i] == maxv[i] : m[i] == 0;
            checks += 4;
            if (cnt[i] !== 12'(m[i])) begin failures++; $display("FAIL rand_count[%0d] n=%0d: got %0d expected %0d", i, n, cnt[i], m[i]); end
            if (w[i] !== mw[i]) begin failures++; $display("FAIL rand_wrap[%0d] n=%0d: got %b expected %b", i, n, w[i], mw[i]); end
            if (al[i] !== exp_al) begin failures++; $display("FAIL rand_atlim[%0d] n=%0d: got %b expected %b", i, n, al[i], exp_al); end
            if (hx[i] !== exp_hex(m[i], ndig[i])) begin failures++; $display("FAIL rand_hex[%0d] n=%0d: got %h expected %h", i, n, hx[i], exp_hex(m[i], ndig[i])); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_wrap();
      test_saturate();
      test_load_clamp();
      test_count_down();
      test_reset_priority();
      test_hex12();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
